// File: rtl/rader7_pkg.sv
// rader7_pkg: shared constants, sample/state types and the slot-to-sample
// lookup used by the rader7_perm input stage.
package rader7_pkg;

  localparam int W        = 8;   // sample width, two's complement
  localparam int N        = 7;   // frame length
  localparam int SLOTS    = 16;  // output slots per frame
  localparam int PERM_LEN = 12;  // slots that carry a sample; the rest are zero

  typedef logic signed [W-1:0] sample_t;
  typedef logic [2:0]          idx_t;
  typedef logic [3:0]          slot_t;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } rd_state_t;

  // Slot to sample index, table {0,5,4,6,2,3,1,5,4,6,2,3}: x[0], the
  // generator-permuted order, then the wrap-around repeat.
  function automatic idx_t perm_idx(input slot_t s);
    idx_t r;
    case (s)
      4'd0:    r = 3'd0;
      4'd1:    r = 3'd5;
      4'd2:    r = 3'd4;
      4'd3:    r = 3'd6;
      4'd4:    r = 3'd2;
      4'd5:    r = 3'd3;
      4'd6:    r = 3'd1;
      4'd7:    r = 3'd5;
      4'd8:    r = 3'd4;
      4'd9:    r = 3'd6;
      4'd10:   r = 3'd2;
      4'd11:   r = 3'd3;
      default: r = 3'd0;
    endcase
    return r;
  endfunction

  // True for slots that carry a buffered sample; the tail slots emit zero.
  function automatic logic slot_live(input slot_t s);
    return (s < slot_t'(PERM_LEN));
  endfunction

endpackage

// File: rtl/rader7_perm_if.sv
// rader7_perm_if: sample-in handshake and frame-out bus of the Rader input
// stage. The slave modport is the design's view, master is the environment.
interface rader7_perm_if;
  import rader7_pkg::*;

  sample_t x_in;
  logic    in_valid;
  logic    in_ready;
  sample_t x_out;
  logic    out_valid;
  logic    frame_start;

  modport master (
    output x_in, in_valid,
    input  in_ready, x_out, out_valid, frame_start
  );

  modport slave (
    input  x_in, in_valid,
    output in_ready, x_out, out_valid, frame_start
  );
endinterface

// File: rtl/rader7_pingpong.sv
// rader7_pingpong: two frame banks with full flags, write/read bank pointers
// and the read mux. The writer fills bank[wb]; the reader drains bank[rb].
// The full flags keep the two sides off the same bank at any one time.
module rader7_pingpong
  import rader7_pkg::*;
(
  input  logic    clk,
  input  logic    reset_n,
  input  logic    wr_en,      // store wr_data at bank[wb][wr_idx]
  input  idx_t    wr_idx,
  input  sample_t wr_data,
  input  logic    wr_last,    // this write completes bank[wb]
  input  logic    rd_done,    // reader finished bank[rb]
  input  idx_t    rd_idx,
  output logic    wr_full,    // full[wb]
  output logic    rd_full,    // full[rb]
  output logic    other_full, // full[~rb]
  output sample_t rd_data
);

  sample_t    bank [2][N];
  logic [1:0] full;
  logic       wb;
  logic       rb;

  // Bank storage, full flags and pointers; writer and reader update
  // different banks so both flag updates may land in the same cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int b = 0; b < 2; b++) begin
        for (int i = 0; i < N; i++) begin
          bank[b][i] <= '0;
        end
      end
      full <= 2'b00;
      wb   <= 1'b0;
      rb   <= 1'b0;
    end else begin
      if (wr_en) begin
        bank[wb][wr_idx] <= wr_data;
      end
      if (wr_en && wr_last) begin
        full[wb] <= 1'b1;
        wb       <= ~wb;
      end
      if (rd_done) begin
        full[rb] <= 1'b0;
        rb       <= ~rb;
      end
    end
  end

  assign wr_full    = full[wb];
  assign rd_full    = full[rb];
  assign other_full = full[~rb];
  assign rd_data    = bank[rb][rd_idx];

endmodule

// File: rtl/rader7_perm.sv
// rader7_perm: input stage for the 7-point Rader DFT core. Collects natural
// order samples into a ping-pong buffer and replays each frame as the
// 16-slot Rader schedule with registered outputs.
// Optional build macro RADER7_PERM_UNDERRUN_EN adds a sticky underrun output
// that flags a gap between frames.
module rader7_perm
  import rader7_pkg::*;
(
  input logic          clk,
  input logic          reset_n,
  rader7_perm_if.slave bus
`ifdef RADER7_PERM_UNDERRUN_EN
  ,
  output logic         underrun
`endif
);

  idx_t      widx;
  logic      xfer;
  logic      wr_last;
  logic      wr_full;
  logic      rd_full;
  logic      other_full;
  logic      rd_done;
  rd_state_t state;
  rd_state_t state_nx;
  slot_t     slot;
  slot_t     slot_nx;
  idx_t      rd_idx;
  sample_t   rd_data;

  assign bus.in_ready = ~wr_full;
  assign xfer         = bus.in_valid & ~wr_full;
  assign wr_last      = (widx == idx_t'(N - 1));
  assign rd_idx       = perm_idx(slot);

  // Writer index: advances on every accepted sample, wraps after x[6].
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      widx <= 3'd0;
    end else if (xfer) begin
      widx <= wr_last ? 3'd0 : widx + 3'd1;
    end
  end

  rader7_pingpong u_pingpong (
    .clk        (clk),
    .reset_n    (reset_n),
    .wr_en      (xfer),
    .wr_idx     (widx),
    .wr_data    (bus.x_in),
    .wr_last    (wr_last),
    .rd_done    (rd_done),
    .rd_idx     (rd_idx),
    .wr_full    (wr_full),
    .rd_full    (rd_full),
    .other_full (other_full),
    .rd_data    (rd_data)
  );

  // Reader state and slot counter.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      slot  <= 4'd0;
    end else begin
      state <= state_nx;
      slot  <= slot_nx;
    end
  end

  // Reader next state: start on a full bank, release the bank after the last
  // slot and chain straight into the next frame when the other bank is ready.
  always_comb begin
    state_nx = state;
    slot_nx  = slot;
    rd_done  = 1'b0;
    case (state)
      IDLE: begin
        slot_nx = 4'd0;
        if (rd_full) begin
          state_nx = RUN;
        end else begin
          state_nx = IDLE;
        end
      end
      RUN: begin
        if (slot == slot_t'(SLOTS - 1)) begin
          rd_done = 1'b1;
          slot_nx = 4'd0;
          if (other_full) begin
            state_nx = RUN;
          end else begin
            state_nx = IDLE;
          end
        end else begin
          slot_nx = slot + 4'd1;
        end
      end
      default: begin
        state_nx = IDLE;
        slot_nx  = 4'd0;
      end
    endcase
  end

  // Registered frame outputs: one slot per cycle while running, zero when idle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bus.x_out       <= '0;
      bus.out_valid   <= 1'b0;
      bus.frame_start <= 1'b0;
    end else if (state == RUN) begin
      bus.x_out       <= slot_live(slot) ? rd_data : '0;
      bus.out_valid   <= 1'b1;
      bus.frame_start <= (slot == 4'd0);
    end else begin
      bus.x_out       <= '0;
      bus.out_valid   <= 1'b0;
      bus.frame_start <= 1'b0;
    end
  end

`ifdef RADER7_PERM_UNDERRUN_EN
  // Sticky gap flag: a frame ended with no further frame buffered.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      underrun <= 1'b0;
    end else if (rd_done && !other_full) begin
      underrun <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_rader7_perm.sv
// tb_rader7_perm: directed, table-driven bench for rader7_perm. Expected
// output frames are hand-computed per vector; the random-gap run uses a
// slot-order reference list.
module tb_rader7_perm;
  import rader7_pkg::*;

  logic clk     = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  rader7_perm_if bus();

`ifdef RADER7_PERM_UNDERRUN_EN
  logic underrun;
  rader7_perm dut (.clk(clk), .reset_n(reset_n), .bus(bus), .underrun(underrun));
`else
  logic underrun;
  assign underrun = 1'b0;
  rader7_perm dut (.clk(clk), .reset_n(reset_n), .bus(bus));
`endif

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
  endtask

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Per-cycle capture of the output side, taken on the falling edge.
  typedef struct packed {
    int         c;
    logic       v;
    logic       fs;
    logic [7:0] x;
    logic       iv;
    logic       ir;
    logic       u;
  } rec_t;
  rec_t mon_q[$];
  logic cap_en = 1'b0;

  always @(negedge clk) begin
    if (cap_en)
      mon_q.push_back('{c: cyc, v: bus.out_valid, fs: bus.frame_start, x: bus.x_out,
                        iv: bus.in_valid, ir: bus.in_ready, u: underrun});
  end

  // Vector table: input frame and hand-computed 16-slot output.
  typedef struct packed {
    logic [6:0][7:0]  x;
    logic [15:0][7:0] y;
  } vec_t;
  vec_t vt[4];

  function automatic logic [6:0][7:0] p7(input logic [7:0] a, b, c, d, e, f, g);
    logic [6:0][7:0] r;
    r[0] = a; r[1] = b; r[2] = c; r[3] = d; r[4] = e; r[5] = f; r[6] = g;
    return r;
  endfunction

  function automatic logic [15:0][7:0] p12(input logic [7:0] a, b, c, d, e, f,
                                           input logic [7:0] g, h, i, j, k, l);
    logic [15:0][7:0] r;
    r[0] = a; r[1] = b; r[2] = c; r[3]  = d; r[4]  = e; r[5]  = f;
    r[6] = g; r[7] = h; r[8] = i; r[9]  = j; r[10] = k; r[11] = l;
    r[12] = 8'd0; r[13] = 8'd0; r[14] = 8'd0; r[15] = 8'd0;
    return r;
  endfunction

  logic [7:0] in_q[$];
  logic [7:0] exp_q[$];
  int first_acc;

  // Feed in_q over the handshake; duty is the in_valid probability in percent.
  task automatic drive(input int duty, input int budget, input string tag);
    int   k = 0;
    int   waited = 0;
    logic will;
    first_acc = -1;
    while (k < in_q.size() && waited < budget) begin
      bus.in_valid = (duty >= 100) ? 1'b1 : ($urandom_range(99) < duty);
      bus.x_in     = bus.in_valid ? in_q[k] : 8'($urandom);
      will = bus.in_valid && bus.in_ready;
      if (will && (k == 6) && (first_acc < 0)) first_acc = cyc + 1;
      @(posedge clk); #1;
      waited++;
      if (will) k++;
    end
    bus.in_valid = 1'b0;
    bus.x_in     = 8'd0;
    chk({tag, "_accepted"}, k, in_q.size());
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Compare the captured valid stream against exp_q.
  task automatic check_stream(input string tag, output int maxrun, output int nfs);
    int nv = 0, bad = 0, fsbad = 0, run = 0;
    maxrun = 0;
    nfs    = 0;
    foreach (mon_q[i]) begin
      if (mon_q[i].v) begin
        if (nv >= exp_q.size() || mon_q[i].x != exp_q[nv]) begin
          if (bad == 0)
            $display("  %s first bad slot %0d: got %0d", tag, nv, $signed(mon_q[i].x));
          bad++;
        end
        if (mon_q[i].fs != ((nv % 16) == 0)) fsbad++;
        if (mon_q[i].fs) nfs++;
        nv++;
        run++;
        if (run > maxrun) maxrun = run;
      end else begin
        run = 0;
      end
    end
    chk({tag, "_count"}, nv, exp_q.size());
    chk({tag, "_data_errors"}, bad, 0);
    chk({tag, "_frame_start_errors"}, fsbad, 0);
  endtask

  task automatic load_vec(input int v);
    for (int i = 0; i < 7; i++) in_q.push_back(vt[v].x[i]);
    for (int i = 0; i < 16; i++) exp_q.push_back(vt[v].y[i]);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    idle_cycles(3);
    @(negedge clk);
    reset_n = 1'b1;
    idle_cycles(1);
    in_q.delete();
    exp_q.delete();
    mon_q.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int maxrun, nfs, low_seen, nvalid, waited, nth, u_at3;
    int ord[16];
    logic [7:0] rx[7];

    bus.x_in     = 8'd0;
    bus.in_valid = 1'b0;
    ord = '{0, 5, 4, 6, 2, 3, 1, 5, 4, 6, 2, 3, -1, -1, -1, -1};

    vt[0].x = p7(8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7);
    vt[0].y = p12(8'd1, 8'd6, 8'd5, 8'd7, 8'd3, 8'd4, 8'd2, 8'd6, 8'd5, 8'd7, 8'd3, 8'd4);
    vt[1].x = p7(8'd11, 8'd12, 8'd13, 8'd14, 8'd15, 8'd16, 8'd17);
    vt[1].y = p12(8'd11, 8'd16, 8'd15, 8'd17, 8'd13, 8'd14, 8'd12, 8'd16, 8'd15, 8'd17, 8'd13, 8'd14);
    vt[2].x = p7(8'd21, 8'd22, 8'd23, 8'd24, 8'd25, 8'd26, 8'd27);
    vt[2].y = p12(8'd21, 8'd26, 8'd25, 8'd27, 8'd23, 8'd24, 8'd22, 8'd26, 8'd25, 8'd27, 8'd23, 8'd24);
    // -128,-1,127,0,-64,64,1
    vt[3].x = p7(8'h80, 8'hFF, 8'h7F, 8'h00, 8'hC0, 8'h40, 8'h01);
    vt[3].y = p12(8'h80, 8'h40, 8'hC0, 8'h01, 8'h7F, 8'h00, 8'hFF, 8'h40, 8'hC0, 8'h01, 8'h7F, 8'h00);

    // Reset state
    #12;
    chk("reset_x_out", int'(bus.x_out), 0);
    chk("reset_out_valid", int'(bus.out_valid), 0);
    chk("reset_frame_start", int'(bus.frame_start), 0);
    chk("reset_in_ready", int'(bus.in_ready), 1);
`ifdef RADER7_PERM_UNDERRUN_EN
    chk("reset_underrun", int'(underrun), 0);
`endif
    do_reset();

    // Single frame 1..7, in_valid held high
    cap_en = 1'b1;
    load_vec(0);
    drive(100, 100, "t1");
    idle_cycles(40);
    check_stream("t1", maxrun, nfs);
    chk("t1_valid_run", maxrun, 16);
    chk("t1_last_cycle_idle", int'(mon_q[mon_q.size() - 1].v), 0);
    nth = -1;
    foreach (mon_q[i]) if (mon_q[i].fs && nth < 0) nth = mon_q[i].c;
    chk("t1_latency_edges", nth - first_acc, 2);
`ifdef RADER7_PERM_UNDERRUN_EN
    chk("t1_underrun_set", int'(underrun), 1);
    idle_cycles(20);
    chk("t1_underrun_sticky", int'(underrun), 1);
`endif
    cap_en = 1'b0;
    do_reset();
`ifdef RADER7_PERM_UNDERRUN_EN
    chk("t2_underrun_cleared", int'(underrun), 0);
`endif

    // Three back-to-back frames
    cap_en = 1'b1;
    load_vec(0); load_vec(1); load_vec(2);
    drive(100, 300, "t2");
    idle_cycles(60);
    check_stream("t2", maxrun, nfs);
    chk("t2_valid_run", maxrun, 48);
    low_seen = 0;
    nth = 0;
    u_at3 = -1;
    foreach (mon_q[i]) begin
      if (mon_q[i].iv && !mon_q[i].ir) low_seen = 1;
      if (mon_q[i].fs) begin
        nth++;
        if (nth == 3) u_at3 = int'(mon_q[i].u);
      end
    end
    chk("t2_ready_throttled", low_seen, 1);
`ifdef RADER7_PERM_UNDERRUN_EN
    chk("t2_no_underrun_streaming", u_at3, 0);
`endif
    cap_en = 1'b0;
    do_reset();

    // Negative samples, bit-exact
    cap_en = 1'b1;
    load_vec(3);
    drive(100, 100, "t3");
    idle_cycles(40);
    check_stream("t3", maxrun, nfs);
    cap_en = 1'b0;
    do_reset();

    // Reset at slot 5 with the second bank full
    cap_en = 1'b1;
    load_vec(0); load_vec(1);
    drive(100, 100, "t4");
    nvalid = 0;
    waited = 0;
    while (nvalid < 6 && waited < 40) begin
      @(negedge clk); #1;
      waited++;
      nvalid = 0;
      foreach (mon_q[i]) if (mon_q[i].v) nvalid++;
    end
    chk("t4_reached_slot5", nvalid, 6);
    chk("t4_both_banks_full", int'(bus.in_ready), 0);
    reset_n = 1'b0;
    #1;
    chk("t4_rst_x_out", int'(bus.x_out), 0);
    chk("t4_rst_out_valid", int'(bus.out_valid), 0);
    chk("t4_rst_frame_start", int'(bus.frame_start), 0);
    idle_cycles(2);
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    chk("t4_ready_after_reset", int'(bus.in_ready), 1);
    in_q.delete(); exp_q.delete(); mon_q.delete();
    load_vec(2);
    drive(100, 100, "t4b");
    idle_cycles(40);
    check_stream("t4b", maxrun, nfs);
    cap_en = 1'b0;
    do_reset();

    // 20 random frames with 50% in_valid duty
    cap_en = 1'b1;
    for (int f = 0; f < 20; f++) begin
      for (int i = 0; i < 7; i++) begin
        rx[i] = 8'($urandom);
        in_q.push_back(rx[i]);
      end
      for (int s = 0; s < 16; s++) exp_q.push_back(ord[s] < 0 ? 8'd0 : rx[ord[s]]);
    end
    drive(50, 3000, "t5");
    idle_cycles(60);
    check_stream("t5", maxrun, nfs);
    chk("t5_frame_starts", nfs, 20);
    cap_en = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/rader7_perm.md
Name: rader7_perm

Overview:
- Input stage placed directly upstream of the 7-point Rader DFT core.
- Accepts real 8-bit samples in natural order x[0]..x[6] over a valid/ready handshake and buffers whole frames in a ping-pong buffer.
- Replays each frame as the fixed 16-slot Rader schedule the core expects: x[0] first, then the generator-permuted order, then the wrap-around repeat.
- Lets upstream logic stream data continuously while the core runs its 16-cycle frame.

Parameters:
- W, 8, sample width in bits (two's complement).
- N, 7, frame length. Fixed; present only for readability and assertions.
- SLOTS, 16, output slots per frame. Matches the core's Start/Load/Run period.

Ports:
- clk  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- x_in  in  W  input sample, natural order.
- in_valid  in  1  x_in is valid this cycle.
- in_ready  out  1  block can accept x_in this cycle.
- x_out  out  W  sample to the DFT core input.
- out_valid  out  1  x_out belongs to an active frame.
- frame_start  out  1  high in slot 0, the cycle that carries x[0].

Behaviour:
- Reset: asynchronous clear of all state.
  - Outputs: x_out=0, out_valid=0, frame_start=0, in_ready=1.
  - Bank full flags = 0, write bank = 0, write index = 0, reader = IDLE.
  - Reset mid-frame discards both banks; no partial frame is ever emitted.
- Buffer: two banks of 7 x W registers, each with a full flag.
- Writer:
  - A transfer occurs when in_valid && in_ready.
  - Each transfer writes x_in to bank[wb][widx], then widx increments.
  - On widx==6, the full flag of bank wb is set, widx returns to 0, and wb toggles.
  - in_ready = !full[wb] (combinational from registered state).
- Reader FSM, states IDLE and RUN, with slot counter s in 0..15:
  - IDLE: if full[rb], go to RUN with s=0 on the next edge. Otherwise out_valid=0 and x_out=0.
  - RUN: all outputs registered.
    - Slot 0 emits x[0].
    - Slots 1..6 emit x[5],x[4],x[6],x[2],x[3],x[1].
    - Slots 7..11 emit x[5],x[4],x[6],x[2],x[3].
    - Slots 12..15 emit 0.
    - out_valid=1 for all 16 slots; frame_start=1 only in slot 0.
  - At s==15:
    - Clear full[rb] and toggle rb.
    - If the other bank is already full, slot 0 of the next frame follows with no gap. Otherwise go to IDLE.
- Latency: slot 0 appears at the output on the second rising edge after the edge that accepts x[6], provided the reader is idle.
- Simultaneous events:
  - The writer setting one bank's full flag and the reader clearing the other bank's flag in the same cycle are independent and both take effect.
  - The writer and reader never touch the same bank in the same cycle. Guaranteed by the full flags.
- Throughput: 7 samples per 16 cycles sustained. in_valid held high throttles via in_ready with no sample lost.
- in_valid while in_ready=0: no transfer. x_in may change freely.

Optional Feature:
- Macro: RADER7_PERM_UNDERRUN_EN.
- When defined:
  - Adds output port underrun (1 bit, sticky).
  - Set when the reader finishes slot 15 after at least one frame and no bank is full, i.e. a frame gap occurs.
  - Cleared only by reset_n.
- When undefined: the port and its logic are absent; all other behaviour is identical.

Decomposition:
- Package rader7_pkg:
  - Constants N=7 and SLOTS=16.
  - PERM table, slot to sample index: {0,5,4,6,2,3,1,5,4,6,2,3}.
  - Reader state enum {IDLE, RUN}.
  - Sample typedef, signed [W-1:0].
- Sub-module rader7_pingpong: two banks, full flags, wb/rb pointers, read mux.
- The top level holds the writer index, the reader FSM and the slot-to-index lookup.

Test Plan:
- Reset, then stream 1..7 with in_valid held high -> frame_start with x_out=1, then 6,5,7,3,4,2,6,5,7,3,4, then 0,0,0,0; out_valid high for 16 cycles, then low.
- Three back-to-back frames 1..7, 11..17, 21..27 with in_valid held high -> 48 contiguous valid slots; in_ready low while both banks are full; no sample lost or duplicated.
- Negative samples -128,-1,127,0,-64,64,1 -> x_out bit-exact two's complement in permuted order (slot 1 = 64, slot 3 = 1).
- Assert reset_n low at slot 5 of a frame with the second bank full -> outputs 0 immediately; after release, in_ready=1 and the next full input frame emits cleanly from slot 0.
- Random in_valid gaps (50% duty) over 20 frames -> output equals a reference permutation model; frame_start count = 20.
- With RADER7_PERM_UNDERRUN_EN: one frame, then idle input -> underrun rises after slot 15 and stays high until reset; never rises under continuous streaming.
